mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//  Sequential 32x32->64 multiply controller for MIPS MULT/MULTU in the EX stage.
//  Time-shares one external RCA_32bit adder, one add per cycle:
//    - operand negation,
//    - 32 shift-add iterations,
//    - final 64-bit negation.
//  start/busy/done handshake to the pipeline stall logic; HI/LO results held until next start.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clk        in   1        rising-edge clock
//  reset_n    in   1        asynchronous, active-low reset
//  start      in   1        request; accepted only when busy==0
//  is_signed  in   1        1=MULT (two's complement), 0=MULTU; sampled with start
//  op_a       in   WIDTH    multiplicand; sampled with start
//  op_b       in   WIDTH    multiplier; sampled with start
//  busy       out  1        high from cycle after accept through done cycle
//  done       out  1        one-cycle pulse; hi/lo valid from this cycle
//  hi         out  WIDTH    product[2W-1:W], registered
//  lo         out  WIDTH    product[W-1:0], registered
//  add_a      out  WIDTH    to shared adder A (combinational from state/regs)
//  add_b      out  WIDTH    to shared adder B
//  add_cin    out  1        to shared adder cin
//  add_sum    in   WIDTH    from shared adder sum (same cycle)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE.
//    busy=0, done=0, hi=0, lo=0, internal regs=0; add_* outputs=0.
//  Carry-out is not provided by the adder. Internal carry c = a[W-1]&b[W-1] | (a[W-1]^b[W-1])&~sum[W-1].
//  States (one cycle each unless noted):
//   IDLE: start=1 -> latch A=op_a, B=op_b, sgn=is_signed, neg=sgn&(op_a[W-1]^op_b[W-1]).
//     Clear P_hi=0, P_lo=op_b (B loads into P_lo). Next NEG_A.
//   NEG_A: adder=(~A,0,cin=1); if sgn&A[W-1], A<=add_sum (magnitude). -> NEG_B
//   NEG_B: adder=(~P_lo,0,cin=1); if sgn&P_lo[W-1], P_lo<=add_sum. -> MUL, cnt=0
//   MUL (WIDTH cycles): adder=(P_hi, P_lo[0]?A:0, cin=0).
//     {P_hi,P_lo} <= {c, add_sum, P_lo[W-1:1]}; cnt++.
//     cnt==W-1 -> NEG_LO
//   NEG_LO: adder=(~P_lo,0,1); if neg, P_lo<=add_sum, k<=c. -> NEG_HI
//   NEG_HI: adder=(~P_hi,0,cin=k); if neg, P_hi<=add_sum. -> DONE
//   DONE: hi<=P_hi, lo<=P_lo visible; done=1; busy=1. -> IDLE (done drops next cycle)
//  Fixed latency: start sampled at edge 0 -> done=1 during cycle 37 (2+32+2+1).
//    New start accepted no earlier than the cycle after done.
//  busy=1 in every state except IDLE.
//  start while busy: ignored, no effect on operands or sequence.
//  hi/lo change only in DONE; otherwise they hold the last result.
//  In non-negating NEG_* cycles the adder still runs; the result is discarded.
//  -2^31 magnitude = 2^31: fits unsigned W bits, no special case.
//  Reset mid-operation: immediate abort to IDLE; hi/lo cleared; no done pulse.
//  add_* during IDLE/DONE = 0 (adder free for other users).
// CONFIGURATION
//  MULT_EARLY_TERM_EN defined:
//    IDLE with start and (op_a==0 or op_b==0) jumps straight to DONE with P=0.
//    done=1 in cycle 1; hi=lo=0.
//  MULT_EARLY_TERM_EN undefined: zero operands take the full 37-cycle path.
//    Result identical (0), timing unchanged.
// TESTING
//  MULTU 3*5 -> busy 1..37, done pulse cycle 37, hi=0x00000000 lo=0x0000000F
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001
//  MULT 0xFFFFFFFF*0x00000001 (-1*1) -> hi=0xFFFFFFFF lo=0xFFFFFFFF
//  MULT 0x80000000*0x80000000 -> hi=0x40000000 lo=0x00000000
//  MULT 7*-3 issued; start pulsed again at cycle 10 with new operands.
//    -> ignored; hi=0xFFFFFFFF lo=0xFFFFFFEB
//  Reset asserted at cycle 20 of a multiply -> busy=0, done never pulses, hi=lo=0.
//    Next MULTU 2*2 -> lo=4.
//    With MULT_EARLY_TERM_EN: MULTU 0*0x1234 -> done at cycle 1, hi=lo=0.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
//   Sequential WIDTH x WIDTH -> 2*WIDTH multiply controller for MIPS
//   MULT/MULTU in the EX stage. One external ripple-carry adder is shared
//   over time. Each cycle does one add, in this order:
//     operand magnitude (NEG_A, NEG_B), WIDTH shift-add steps (MUL),
//     conditional 2*WIDTH-bit negation of the product (NEG_LO, NEG_HI).
//   start/busy/done connect to the pipeline stall logic. hi/lo hold the last
//   result until the next DONE.
//
// Optional feature (compile-time macro MULT_EARLY_TERM_EN):
//   When it is defined, a start with a zero operand goes directly to DONE
//   with a zero product. done is then high in cycle 1.
//   When it is undefined, zero operands take the full-length path.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   start      in   1      request, accepted only when idle
//   is_signed  in   1      1 = MULT, 0 = MULTU (sampled with start)
//   op_a       in   WIDTH  multiplicand (sampled with start)
//   op_b       in   WIDTH  multiplier   (sampled with start)
//   busy       out  1      high in every state except IDLE
//   done       out  1      one-cycle pulse; hi/lo valid from this cycle
//   hi, lo     out  WIDTH  registered product halves
//   add_a      out  WIDTH  shared adder operand A (zero when unused)
//   add_b      out  WIDTH  shared adder operand B (zero when unused)
//   add_cin    out  1      shared adder carry-in (zero when unused)
//   add_sum    in   WIDTH  shared adder sum (combinational, same cycle)
// ---------------------------------------------------------------------------
module mult_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_NEG_A, S_NEG_B, S_MUL, S_NEG_LO, S_NEG_HI, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q;        // multiplicand, then its magnitude
    logic [WIDTH-1:0] p_hi_q;     // upper half of the partial product
    logic [WIDTH-1:0] p_lo_q;     // holds the multiplier at first; product bits shift in from the top
    logic             sgn_q;      // signed operation
    logic             neg_q;      // final product must be negated
    logic             k_q;        // carry from the low half into the high half during negation
    logic [CW-1:0]    cnt_q;
    logic             carry;

    // The adder does not output its carry. Reconstruct it from the MSBs of
    // the operands and the sum.
    assign carry = (add_a[WIDTH-1] & add_b[WIDTH-1])
                 | ((add_a[WIDTH-1] ^ add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);

`ifdef MULT_EARLY_TERM_EN
    logic zero_op;
    assign zero_op = (op_a == '0) || (op_b == '0);
`endif

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    // NOTE: sequential state uses non-blocking assignments (<=) so that every
    // flop samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: each signal driven from always_comb gets its default value first.
    // This way no path can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_NEG_A;
`ifdef MULT_EARLY_TERM_EN
                    if (zero_op) state_d = S_DONE;
`endif
                end
            end
            S_NEG_A: begin
                add_a   = ~a_q;
                add_cin = 1'b1;
                state_d = S_NEG_B;
            end
            S_NEG_B: begin
                add_a   = ~p_lo_q;
                add_cin = 1'b1;
                state_d = S_MUL;
            end
            S_MUL: begin
                add_a = p_hi_q;
                add_b = p_lo_q[0] ? a_q : '0;
                if (cnt_q == LAST_ITER) state_d = S_NEG_LO;
            end
            S_NEG_LO: begin
                add_a   = ~p_lo_q;
                add_cin = 1'b1;
                state_d = S_NEG_HI;
            end
            S_NEG_HI: begin
                add_a   = ~p_hi_q;
                add_cin = k_q;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath. In a NEG_* cycle that does not negate, the adder result is
    // discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            p_hi_q <= '0;
            p_lo_q <= '0;
            sgn_q  <= 1'b0;
            neg_q  <= 1'b0;
            k_q    <= 1'b0;
            cnt_q  <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= op_a;
                        sgn_q  <= is_signed;
                        neg_q  <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        p_hi_q <= '0;
                        p_lo_q <= op_b;
                        k_q    <= 1'b0;
                        cnt_q  <= '0;
`ifdef MULT_EARLY_TERM_EN
                        if (zero_op) begin
                            p_lo_q <= '0;
                            hi     <= '0;
                            lo     <= '0;
                        end
`endif
                    end
                end
                S_NEG_A: if (sgn_q && a_q[WIDTH-1]) a_q <= add_sum;
                S_NEG_B: begin
                    if (sgn_q && p_lo_q[WIDTH-1]) p_lo_q <= add_sum;
                    cnt_q <= '0;
                end
                S_MUL: begin
                    // Shift right one bit. The adder carry becomes the new top
                    // bit, and the LSB of the sum moves into p_lo.
                    p_hi_q <= {carry, add_sum[WIDTH-1:1]};
                    p_lo_q <= {add_sum[0], p_lo_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q + 1'b1;
                end
                S_NEG_LO: begin
                    if (neg_q) begin
                        p_lo_q <= add_sum;
                        k_q    <= carry;
                    end
                end
                S_NEG_HI: begin
                    // Load hi/lo here so the result is visible during DONE.
                    if (neg_q) p_hi_q <= add_sum;
                    hi <= neg_q ? add_sum : p_hi_q;
                    lo <= p_lo_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_ctrl
//   Scoreboard bench for mult_seq_ctrl. A driver issues directed and random
//   multiplies. For each one it pushes the product computed with plain
//   64-bit arithmetic, together with the expected done cycle. A monitor pops
//   an entry on every done pulse. Between pulses it checks that hi/lo hold
//   their value and that the adder bus is zero while the adder is unused.
//   The shared adder is modelled here as a plain combinational sum.
// ---------------------------------------------------------------------------
module tb_mult_seq_ctrl;

    localparam int W = 32;
    localparam int FULL_LAT = 37;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo, add_a, add_b, add_sum;
    logic         add_cin;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum)
    );

    assign add_sum = add_a + add_b + {{(W-1){1'b0}}, add_cin};

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] prod;
        int unsigned due;   // value of cyc at the negedge where done must be seen
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
        longint sa, sb_;
        if (s) begin
            sa  = longint'($signed(a));
            sb_ = longint'($signed(b));
            return 64'(sa * sb_);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
        if (a == '0 || b == '0) return 1;
`endif
        return FULL_LAT;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            last_hi = '0;
            last_lo = '0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("hi", 64'(hi), 64'(e.prod[63:32]));
                    check("lo", 64'(lo), 64'(e.prod[31:0]));
                    check("done_cycle", 64'(cyc), 64'(e.due));
                    check("busy_at_done", 64'(busy), 64'd1);
                    last_hi = e.prod[63:32];
                    last_lo = e.prod[31:0];
                end
            end else begin
                check("hi_hold", 64'(hi), 64'(last_hi));
                check("lo_hold", 64'(lo), 64'(last_lo));
            end
            if (!busy || done) begin
                check("adder_idle", {31'b0, add_cin, add_a}, 64'd0);
                check("adder_idle_b", 64'(add_b), 64'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        int   guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) check("idle_before_issue", 64'(busy), 64'd0);
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        is_signed = s;
        e.prod    = ref_mul(a, b, s);
        e.due     = cyc + ref_lat(a, b);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    // Wait for the operation to finish. If spur >= 0, a start carrying junk
    // operands is pulsed while busy; it must be ignored.
    task automatic wait_idle(input int spur);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (i == spur) begin
                start     = 1'b1;
                op_a      = $urandom;
                op_b      = $urandom;
                is_signed = $urandom_range(0, 1);
            end
            @(negedge clk);
            start = 1'b0;
        end
        if (!ok) check("timeout_idle", 64'(busy), 64'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int spur);
        issue(a, b, s);
        wait_idle(spur);
    endtask

    logic [W-1:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_adder", {31'b0, add_cin, add_a}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(32'd3, 32'd5, 1'b0, -1);
        check("idle_after_done", 64'(busy), 64'd0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, -1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1);
        run_op(32'd7, 32'hFFFF_FFFD, 1'b1, 8);        // spurious start while busy
        check("lo_7x-3", 64'(lo), 64'hFFFF_FFEB);
        check("hi_7x-3", 64'(hi), 64'hFFFF_FFFF);

        // Reset in the middle of an operation: abort, no done pulse, hi/lo cleared
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (18) @(negedge clk);
        #1 reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        run_op(32'd2, 32'd2, 1'b0, -1);
        check("lo_2x2", 64'(lo), 64'd4);

        // Zero operands (the latency expected depends on the build)
        run_op(32'd0, 32'h1234, 1'b0, -1);
        run_op(32'hDEAD_BEEF, 32'd0, 1'b1, -1);

        // Random traffic, including back-to-back issues and spurious starts
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a, b;
            int           spur;
            a    = pick();
            b    = pick();
            spur = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : -1;
            run_op(a, b, 1'($urandom_range(0, 1)), spur);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
